// File: rtl/axi_wrr_arbiter_pkg.sv
// Shared definitions for the AXI weighted round-robin arbiter slice:
// arbitration state encoding, priority-direction constants and a
// one-hot to binary index helper.
package axi_arb_pkg;

  // Arbiter tenure state: no owner, or one port holds the channel.
  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_e;

  // Values accepted by the LSB_PRIORITY parameter.
  localparam string PRIO_LOW  = "LOW";
  localparam string PRIO_HIGH = "HIGH";

  // Largest one-hot vector the index helper understands.
  localparam int ONEHOT_MAX_W = 32;

  // Binary index of the set bit in a one-hot vector (0 for an all-zero input).
  // OR-ing the indices of set bits avoids a priority chain; the input is
  // guaranteed one-hot by construction wherever this is used.
  function automatic int unsigned onehot_to_index(input logic [ONEHOT_MAX_W-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < ONEHOT_MAX_W; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/axi_wrr_arbiter_if.sv
// Request/grant bundle between a set of AXI requesters and the weighted
// round-robin arbiter. The arbiter uses the slave modport, the requester
// side (or a bench) the master modport.
interface axi_wrr_arbiter_if #(
  parameter int PORTS    = 4,
  parameter int WEIGHT_W = 4
);

  localparam int IDX_W = $clog2(PORTS);

  logic [PORTS-1:0]          request;
  logic [PORTS-1:0]          acknowledge;
  logic [PORTS*WEIGHT_W-1:0] weight;
  logic [PORTS-1:0]          grant;
  logic                      grant_valid;
  logic [IDX_W-1:0]          grant_encoded;
  logic [WEIGHT_W-1:0]       grant_credit;

  // Arbiter side: consumes requests/strobes/weights, produces the grant.
  modport slave (
    input  request,
    input  acknowledge,
    input  weight,
    output grant,
    output grant_valid,
    output grant_encoded,
    output grant_credit
  );

  // Requester side: drives requests/strobes/weights, observes the grant.
  modport master (
    output request,
    output acknowledge,
    output weight,
    input  grant,
    input  grant_valid,
    input  grant_encoded,
    input  grant_credit
  );

endinterface

// File: rtl/axi_priority_encoder.sv
// Fixed-priority encoder: picks one set bit of request, lowest index first
// ("LOW") or highest index first ("HIGH"), and reports it both one-hot and
// as a binary index.
module axi_priority_encoder
  import axi_arb_pkg::*;
#(
  parameter int    WIDTH        = 4,
  parameter string LSB_PRIORITY = "LOW",
  localparam int   IDX_W        = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] request,
  output logic             valid,
  output logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] index
);

  localparam bit PRIO_HI = (LSB_PRIORITY == PRIO_HIGH);

  logic found;

  // Walk the request vector in priority order and keep the first set bit.
  always_comb begin
    onehot = '0;
    found  = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (PRIO_HI) begin
        if (request[WIDTH-1-k] && !found) begin
          onehot[WIDTH-1-k] = 1'b1;
          found             = 1'b1;
        end
      end else begin
        if (request[k] && !found) begin
          onehot[k] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

  assign valid = |request;
  assign index = IDX_W'(onehot_to_index(ONEHOT_MAX_W'(onehot)));

endmodule

// File: rtl/axi_wrr_arbiter.sv
// Weighted round-robin arbiter for PORTS requesters sharing one AXI channel.
// A winning port keeps the grant for up to max(weight,1) acknowledged
// transfers, or until it drops its request. Re-arbitration happens in the
// release cycle itself, so back-to-back tenures have no idle bubble.
module axi_wrr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int    PORTS        = 4,
  parameter int    WEIGHT_W     = 4,
  parameter string LSB_PRIORITY = "LOW"
) (
  input logic              clk,
  input logic              rst,
  axi_wrr_arbiter_if.slave bus
);

  localparam int IDX_W   = $clog2(PORTS);
  localparam bit PRIO_HI = (LSB_PRIORITY == PRIO_HIGH);

  // A programmed weight of zero still allows one transfer per tenure.
  function automatic logic [WEIGHT_W-1:0] sat_weight(input logic [WEIGHT_W-1:0] w);
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  arb_state_e          state, state_nxt;
  logic [PORTS-1:0]    grant_oh, grant_oh_nxt;
  logic [IDX_W-1:0]    grant_idx, grant_idx_nxt;
  logic [WEIGHT_W-1:0] credit, credit_nxt;
  logic [PORTS-1:0]    mask, mask_nxt;

  logic                ack_g;
  logic                req_g;
  logic                release_now;

  logic                all_valid, masked_valid;
  logic [PORTS-1:0]    all_oh, masked_oh;
  logic [IDX_W-1:0]    all_idx, masked_idx;

  logic [PORTS-1:0]    win_oh;
  logic [IDX_W-1:0]    win_idx;
  logic [WEIGHT_W-1:0] win_credit;
  logic [PORTS-1:0]    win_mask;

  // Unmasked search: fallback when nobody past the last owner is requesting.
  axi_priority_encoder #(
    .WIDTH        (PORTS),
    .LSB_PRIORITY (LSB_PRIORITY)
  ) u_enc_all (
    .request (bus.request),
    .valid   (all_valid),
    .onehot  (all_oh),
    .index   (all_idx)
  );

  // Masked search: only ports after the last owner in rotation order.
  axi_priority_encoder #(
    .WIDTH        (PORTS),
    .LSB_PRIORITY (LSB_PRIORITY)
  ) u_enc_masked (
    .request (bus.request & mask),
    .valid   (masked_valid),
    .onehot  (masked_oh),
    .index   (masked_idx)
  );

  // The last owner is never in the mask, so it can only win again through
  // the unmasked search, i.e. when it is the only requester left.
  assign win_oh     = masked_valid ? masked_oh  : all_oh;
  assign win_idx    = masked_valid ? masked_idx : all_idx;
  assign win_credit = sat_weight(bus.weight[win_idx*WEIGHT_W +: WEIGHT_W]);

  // Rotation mask for the next search: ports strictly after the winner.
  always_comb begin
    win_mask = '0;
    for (int i = 0; i < PORTS; i++) begin
      win_mask[i] = PRIO_HI ? (i < int'(win_idx)) : (i > int'(win_idx));
    end
  end

  // Release is decided from the registered owner and credit. A request drop
  // releases even when it coincides with an acknowledge; that ack still
  // counts but the credit is replaced by the next tenure anyway.
  assign ack_g       = bus.acknowledge[grant_idx];
  assign req_g       = bus.request[grant_idx];
  assign release_now = (state == ARB_GRANTED) &&
                       ((ack_g && (credit == WEIGHT_W'(1))) || !req_g);

  // Next-state and next-grant logic: hold, count down, or re-arbitrate.
  always_comb begin
    state_nxt     = state;
    grant_oh_nxt  = grant_oh;
    grant_idx_nxt = grant_idx;
    credit_nxt    = credit;
    mask_nxt      = mask;
    case (state)
      ARB_IDLE: begin
        if (all_valid) begin
          state_nxt     = ARB_GRANTED;
          grant_oh_nxt  = win_oh;
          grant_idx_nxt = win_idx;
          credit_nxt    = win_credit;
          mask_nxt      = win_mask;
        end
      end
      ARB_GRANTED: begin
        if (release_now) begin
          if (all_valid) begin
            grant_oh_nxt  = win_oh;
            grant_idx_nxt = win_idx;
            credit_nxt    = win_credit;
            mask_nxt      = win_mask;
          end else begin
            state_nxt     = ARB_IDLE;
            grant_oh_nxt  = '0;
            grant_idx_nxt = '0;
            credit_nxt    = '0;
          end
        end else if (ack_g) begin
          credit_nxt = credit - WEIGHT_W'(1);
        end
      end
      default: begin
        state_nxt     = ARB_IDLE;
        grant_oh_nxt  = '0;
        grant_idx_nxt = '0;
        credit_nxt    = '0;
        mask_nxt      = '0;
      end
    endcase
  end

  // State, grant, credit and rotation mask registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      grant_oh  <= '0;
      grant_idx <= '0;
      credit    <= '0;
      mask      <= '0;
    end else begin
      state     <= state_nxt;
      grant_oh  <= grant_oh_nxt;
      grant_idx <= grant_idx_nxt;
      credit    <= credit_nxt;
      mask      <= mask_nxt;
    end
  end

  assign bus.grant         = grant_oh;
  assign bus.grant_valid   = (state == ARB_GRANTED);
  assign bus.grant_encoded = grant_idx;
  assign bus.grant_credit  = credit;

endmodule
